// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch resolve queue.
package branch_pkg;

    localparam int unsigned PC_W = 32;
    localparam int unsigned CNT_STAT_W = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
    } bq_entry_t;

    localparam int unsigned ENTRY_W = $bits(bq_entry_t);

    // Pointer width for a ring of the given depth; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/bq_storage.sv
// DEPTH-entry register ring: one synchronous write port, one combinational read port.
module bq_storage
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  bq_entry_t        wr_data,
    input  logic [PTR_W-1:0] rd_ptr,
    output bq_entry_t        rd_data
);

    bq_entry_t mem [DEPTH];

    // Contents need no reset: validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branches; resolves the oldest, updates the predictor
// and squashes younger entries on a mispredict.
module branch_resolve_queue
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [31:0]              alloc_pc,
    input  logic                     alloc_pred_taken,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    input  logic                     flush,
    output logic                     update_en,
    output logic [31:0]              update_pc,
    output logic                     actual_taken,
    output logic                     mispredict,
    output logic                     resolve_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              branch_cnt,
    output logic [31:0]              mispredict_cnt
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_d;
    logic [PTR_W-1:0] tail_d;
    logic [CNT_W-1:0] count_d;

    logic      push_ok;
    logic      pop_ok;
    logic      mis_c;
    logic      err_c;
    logic      wr_en;
    bq_entry_t wr_data;
    bq_entry_t head_entry;

    bq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_ptr  (tail),
        .wr_data (wr_data),
        .rd_ptr  (head),
        .rd_data (head_entry)
    );

    assign alloc_ready = (count != CNT_W'(DEPTH));

    // Pop, push and squash decisions for this cycle.
    always_comb begin
        push_ok         = alloc_valid && alloc_ready;
        pop_ok          = resolve_valid && (count != '0);
        err_c           = resolve_valid && (count == '0);
        mis_c           = pop_ok && (resolve_taken != head_entry.pred_taken);
        wr_data.pc         = alloc_pc;
        wr_data.pred_taken = alloc_pred_taken;
        wr_en           = push_ok && !flush && !mis_c;
        head_d          = head;
        tail_d          = tail;
        count_d         = count;

        if (flush || mis_c) begin
            // Everything still queued, and any same-cycle push, is younger than the pop.
            head_d  = tail;
            count_d = '0;
        end else begin
            if (pop_ok) begin
                head_d = PTR_W'(head + PTR_W'(1));
            end
            if (push_ok) begin
                tail_d = PTR_W'(tail + PTR_W'(1));
            end
            count_d = CNT_W'(count + CNT_W'(push_ok) - CNT_W'(pop_ok));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            update_en      <= 1'b0;
            update_pc      <= '0;
            actual_taken   <= 1'b0;
            mispredict     <= 1'b0;
            resolve_err    <= 1'b0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            head        <= head_d;
            tail        <= tail_d;
            count       <= count_d;
            update_en   <= pop_ok;
            mispredict  <= mis_c;
            resolve_err <= err_c;
            // A resolve is reported even under flush: that branch has executed.
            if (pop_ok) begin
                update_pc    <= head_entry.pc;
                actual_taken <= resolve_taken;
                branch_cnt   <= branch_cnt + 32'd1;
            end
            if (mis_c) begin
                mispredict_cnt <= mispredict_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized + directed bench with a queue-based reference model and a scoreboard monitor.
module tb_branch_resolve_queue;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alloc_valid = 1'b0;
    logic        alloc_ready;
    logic [31:0] alloc_pc = '0;
    logic        alloc_pred_taken = 1'b0;
    logic        resolve_valid = 1'b0;
    logic        resolve_taken = 1'b0;
    logic        flush = 1'b0;
    logic        update_en;
    logic [31:0] update_pc;
    logic        actual_taken;
    logic        mispredict;
    logic        resolve_err;
    logic [3:0]  count;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    branch_resolve_queue #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_valid      (alloc_valid),
        .alloc_ready      (alloc_ready),
        .alloc_pc         (alloc_pc),
        .alloc_pred_taken (alloc_pred_taken),
        .resolve_valid    (resolve_valid),
        .resolve_taken    (resolve_taken),
        .flush            (flush),
        .update_en        (update_en),
        .update_pc        (update_pc),
        .actual_taken     (actual_taken),
        .mispredict       (mispredict),
        .resolve_err      (resolve_err),
        .count            (count),
        .branch_cnt       (branch_cnt),
        .mispredict_cnt   (mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        bit          pred;
    } ent_t;

    typedef struct {
        bit          err;
        logic [31:0] pc;
        bit          taken;
        bit          mis;
    } exp_t;

    ent_t        mq[$];
    exp_t        exp_q[$];
    logic [31:0] m_bcnt = '0;
    logic [31:0] m_mcnt = '0;
    logic [31:0] m_last_pc = '0;
    bit          m_last_t = 1'b0;
    bit          started = 1'b0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: applies one clock edge's worth of inputs to the queue.
    task automatic model_edge();
        ent_t e;
        exp_t x;
        bit   mis;
        bit   do_push;
        if (rst) begin
            mq.delete();
            m_bcnt = '0;
            m_mcnt = '0;
            m_last_pc = '0;
            m_last_t = 1'b0;
            return;
        end
        do_push = alloc_valid && (mq.size() < DEPTH);
        mis = 1'b0;
        if (resolve_valid && mq.size() == 0) begin
            x = '{err: 1'b1, pc: '0, taken: 1'b0, mis: 1'b0};
            exp_q.push_back(x);
        end else if (resolve_valid) begin
            e = mq.pop_front();
            mis = (resolve_taken != e.pred);
            x = '{err: 1'b0, pc: e.pc, taken: resolve_taken, mis: mis};
            exp_q.push_back(x);
            m_bcnt++;
            if (mis) m_mcnt++;
            m_last_pc = e.pc;
            m_last_t = resolve_taken;
        end
        if (flush || mis) begin
            mq.delete();
        end else if (do_push) begin
            e = '{pc: alloc_pc, pred: alloc_pred_taken};
            mq.push_back(e);
        end
    endtask

    task automatic step(input bit av, input logic [31:0] pc, input bit pt,
                        input bit rv, input bit rt, input bit fl, input bit r);
        alloc_valid = av;
        alloc_pc = pc;
        alloc_pred_taken = pt;
        resolve_valid = rv;
        resolve_taken = rt;
        flush = fl;
        rst = r;
        @(posedge clk);
        model_edge();
        started = 1'b1;
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input bit pt);
        step(1'b1, pc, pt, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic res(input bit rt);
        step(1'b0, '0, 1'b0, 1'b1, rt, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: every expected response must appear exactly one cycle later.
    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            if (update_en || resolve_err) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: update_en=%0b resolve_err=%0b want none at %0t",
                             update_en, resolve_err, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("resolve_err", 32'(resolve_err), 32'(e.err));
                    chk("update_en", 32'(update_en), 32'(!e.err));
                    if (!e.err) begin
                        chk("update_pc", update_pc, e.pc);
                        chk("actual_taken", 32'(actual_taken), 32'(e.taken));
                        chk("mispredict", 32'(mispredict), 32'(e.mis));
                    end
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                bad++;
                $display("FAIL missing_out: got no output want err=%0b pc=0x%0h at %0t",
                         e.err, e.pc, $time);
            end
            if (!update_en) chk("mispredict_idle", 32'(mispredict), 32'd0);
            chk("hold_pc", update_pc, m_last_pc);
            chk("hold_taken", 32'(actual_taken), 32'(m_last_t));
            chk("count", 32'(count), 32'(mq.size()));
            chk("alloc_ready", 32'(alloc_ready), 32'(mq.size() < DEPTH));
            chk("branch_cnt", branch_cnt, m_bcnt);
            chk("mispredict_cnt", mispredict_cnt, m_mcnt);
        end
    end

    initial begin
        int n;
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();

        push(32'h100, 1'b1);
        res(1'b1);
        idle();

        push(32'h200, 1'b0);
        push(32'h204, 1'b0);
        push(32'h208, 1'b1);
        res(1'b1);
        idle();
        res(1'b0);
        idle();

        for (int i = 0; i < 9; i++) push(32'h1000 + 32'(i * 4), 1'b1);
        for (int i = 0; i < 10; i++) begin
            res(1'b1);
            push(32'h2000 + 32'(i * 4), 1'b1);
        end
        for (int i = 0; i < 9; i++) res(1'b1);
        idle();

        res(1'b0);
        idle();

        push(32'h300, 1'b1);
        step(1'b1, 32'h304, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();

        push(32'h400, 1'b0);
        push(32'h404, 1'b1);
        step(1'b1, 32'h408, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle();

        for (int i = 0; i < 5; i++) push(32'h500 + 32'(i * 4), 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();

        for (int i = 0; i < 3000; i++) begin
            n = $urandom_range(0, 99);
            step($urandom_range(0, 99) < 60, $urandom, 1'($urandom),
                 $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 75,
                 $urandom_range(0, 99) < 3, n < 1);
        end
        idle();
        idle();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order queue of in-flight conditional branches, sitting between fetch and the SIC execute stage. It records each branch's PC and predicted direction at fetch. When execute resolves the oldest branch, it compares the actual direction with the prediction. It then drives the predictor's update port (update_en / update_pc / actual_taken) and raises a mispredict pulse that squashes all younger queued branches.

## Interface
- DEPTH, 8: queue entries; power of two, ≥ 2.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- alloc_valid  in  1  fetch pushes a predicted branch this cycle.
- alloc_ready  out  1  queue can accept; = !full.
- alloc_pc  in  32  branch PC.
- alloc_pred_taken  in  1  predictor output at fetch.
- resolve_valid  in  1  execute resolves the oldest outstanding branch.
- resolve_taken  in  1  actual direction.
- flush  in  1  external pipeline flush (exception); discards all entries, no update.
- update_en  out  1  one-cycle pulse to the predictor.
- update_pc  out  32  PC of the resolved branch.
- actual_taken  out  1  resolved direction.
- mispredict  out  1  one-cycle pulse; resolved direction ≠ stored prediction.
- resolve_err  out  1  one-cycle pulse; resolve_valid while the queue is empty.
- count  out  $clog2(DEPTH)+1  current occupancy.
- branch_cnt  out  32  total successful resolves; wraps at 2^32.
- mispredict_cnt  out  32  total mispredicts; wraps at 2^32.

## Operation
- Storage is a ring of DEPTH entries {pc, pred_taken} with head, tail and count.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
- Push: alloc_valid && alloc_ready writes the entry at tail; tail++.
- Resolve: resolve_valid && count≠0 pops the head; head++.
  - Next cycle: update_en=1, update_pc=head.pc, actual_taken=resolve_taken.
  - mispredict = (resolve_taken ≠ head.pred_taken); branch_cnt++, and mispredict_cnt++ when mispredicting.
- Mispredict squash: at the same edge as the pop, all remaining entries are discarded.
  - head=tail, count=0.
  - A push accepted in that same cycle is also discarded (it is younger).
- Resolve on empty: no pop, no update; resolve_err=1 next cycle; counters unchanged.
- Simultaneous push and pop without mispredict: count unchanged, both pointers advance.
- Full: alloc_ready=0. There is no same-cycle bypass of a pop into a free slot.
- flush has priority over everything in its cycle.
  - The queue empties and any push is dropped.
  - A concurrent resolve is still reported (update_en, mispredict, counters), because that branch has executed.
- Outputs update_en, update_pc, actual_taken, mispredict and resolve_err are registered.
- update_pc and actual_taken hold their last value when update_en=0.

## Timing
- Reset (rst high at an edge): head=tail=count=0.
  - update_en, mispredict and resolve_err are 0; update_pc=0, actual_taken=0.
  - branch_cnt=mispredict_cnt=0; alloc_ready=1 from the first cycle after reset.
- Reset mid-operation drops all entries; any update pending from that cycle is suppressed.
- Resolve-to-update latency is exactly 1 cycle; the predictor sees the update at edge N+2 for a resolve in cycle N.
- count and alloc_ready reflect registered state only (combinational from count).
- Back-to-back resolves every cycle are supported; updates are issued one per cycle in program order.

## Structure
- Shared package branch_pkg:
  - bq_entry_t {logic [31:0] pc; logic pred_taken;}
  - a function to compute the pointer width from DEPTH.
- One sub-module, bq_storage: a DEPTH×33 register ring with a write port (wr_en, wr_ptr, wr_data) and a combinational read port (rd_ptr → rd_data).
- Control, pointer logic and counters stay in branch_resolve_queue.

## Test plan
- Reset, then push PC 0x100 predicted taken and resolve taken -> next cycle update_en=1, update_pc=0x100, actual_taken=1, mispredict=0, branch_cnt=1.
- Push 0x200(pred 0), 0x204(pred 0), 0x208(pred 1); resolve 0x200 taken -> mispredict=1, count=0 after the edge, mispredict_cnt=1; a later resolve gives resolve_err=1.
- Push 8 entries with DEPTH=8 -> alloc_ready=0 and a 9th push is ignored. Then pop one and push one in separate cycles, ten times -> pointers wrap, update_pc values follow FIFO order.
- Resolve with the queue empty -> resolve_err=1 for one cycle, update_en=0, counters unchanged.
- Mispredicting resolve plus push in the same cycle -> the push is dropped, count=0.
- flush plus a correct resolve in the same cycle -> update_en=1, count=0.
- Assert rst with 5 entries queued and a resolve in flight -> next cycle count=0, update_en=0, both counters 0, alloc_ready=1.
